// File: rtl/ctrl_pkg.sv
// Shared constants for the console/instruction sequencer: opcodes, console modes,
// FSM states and the bit layout of the packed control word.
package ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        LEN_SHORT  = 2'd0,
        LEN_NORMAL = 2'd1,
        LEN_LONG   = 2'd2
    } ilen_e;

    localparam logic [2:0] MODE_RUN  = 3'b000;
    localparam logic [2:0] MODE_WMEM = 3'b001;
    localparam logic [2:0] MODE_RMEM = 3'b010;
    localparam logic [2:0] MODE_RREG = 3'b011;
    localparam logic [2:0] MODE_WREG = 3'b100;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_INC = 4'b0100;
    localparam logic [3:0] OP_LD  = 4'b0101;
    localparam logic [3:0] OP_ST  = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_JMP = 4'b1001;
    localparam logic [3:0] OP_XOR = 4'b1010;
    localparam logic [3:0] OP_DEC = 4'b1011;
    localparam logic [3:0] OP_STP = 4'b1110;

    // Control word, MSB first: drw pcinc lpc lar pcadd arinc selctl memw lir ldz ldc cin s[3:0] m abus sbus mbus sel[3:0]
    localparam int CTL_W      = 24;
    localparam int CTL_SEL    = 0;
    localparam int CTL_MBUS   = 4;
    localparam int CTL_SBUS   = 5;
    localparam int CTL_ABUS   = 6;
    localparam int CTL_M      = 7;
    localparam int CTL_S      = 8;
    localparam int CTL_CIN    = 12;
    localparam int CTL_LDC    = 13;
    localparam int CTL_LDZ    = 14;
    localparam int CTL_LIR    = 15;
    localparam int CTL_MEMW   = 16;
    localparam int CTL_SELCTL = 17;
    localparam int CTL_ARINC  = 18;
    localparam int CTL_PCADD  = 19;
    localparam int CTL_LAR    = 20;
    localparam int CTL_LPC    = 21;
    localparam int CTL_PCINC  = 22;
    localparam int CTL_DRW    = 23;

    // Undefined opcodes fall into the short class so they behave as NOP.
    function automatic ilen_e op_len(input logic [3:0] op);
        ilen_e len;
        case (op)
            OP_LD, OP_ST: len = LEN_LONG;
            OP_ADD, OP_SUB, OP_AND, OP_INC, OP_JC, OP_JZ,
            OP_JMP, OP_XOR, OP_DEC, OP_STP: len = LEN_NORMAL;
            default: len = LEN_SHORT;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/beat_gen.sv
// One-hot beat ring W1..Wn: ends after W1 (short), W2 (normal), W3 (long) or W4 (len4),
// and parks on W1 while hold is high.
module beat_gen #(
    parameter int NBEAT = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             hold,
    input  logic             short_i,
    input  logic             long_i,
    input  logic             len4_i,
    output logic [NBEAT-1:0] beat,
    output logic             last
);

    logic [NBEAT-1:0] beat_q, beat_d;

    always_comb begin
        last = 1'b0;
        if (beat_q[0] && short_i) last = 1'b1;
        if (beat_q[1] && !long_i && !len4_i) last = 1'b1;
        if (beat_q[2] && !len4_i) last = 1'b1;
        if (beat_q[NBEAT-1]) last = 1'b1;

        beat_d = {beat_q[NBEAT-2:0], 1'b0};
        if (hold || last) beat_d = {{(NBEAT-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) beat_q <= {{(NBEAT-1){1'b0}}, 1'b1};
        else      beat_q <= beat_d;
    end

    assign beat = beat_q;

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired console/instruction sequencer: console register/memory modes, program
// fetch/execute, and a halt state that only clr leaves.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int OPW   = 4,
    parameter int NBEAT = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             qd,
    input  logic [2:0]       sw,
    input  logic [OPW-1:0]   ir,
    input  logic             c,
    input  logic             z,
    output logic [NBEAT-1:0] beat,
    output logic             st0,
    output logic [CTL_W-1:0] ctl,
    output logic             stop,
    output logic             halted
);

    state_e     state_q, state_d;
    logic [2:0] mode_q, mode_d;
    logic       st0_q, st0_d;
    logic [1:0] reg_idx_q, reg_idx_d;
    logic [3:0] op;
    logic       seq_short, seq_long, beat_last;

    assign op = ir[OPW-1:OPW-4];

    always_comb begin
        seq_short = 1'b0;
        seq_long  = 1'b0;
        case (mode_q)
            MODE_WREG, MODE_RREG: ;
            MODE_RUN: begin
                if (!st0_q) seq_short = 1'b1;
                else begin
                    case (op_len(op))
                        LEN_SHORT: seq_short = 1'b1;
                        LEN_LONG:  seq_long  = 1'b1;
                        default:   ;
                    endcase
                end
            end
            default: seq_short = 1'b1;
        endcase
    end

    beat_gen #(.NBEAT(NBEAT)) u_beat_gen (
        .clk     (clk),
        .clr     (clr),
        .hold    (state_q != ST_RUN),
        .short_i (seq_short),
        .long_i  (seq_long),
        .len4_i  (1'b0),
        .beat    (beat),
        .last    (beat_last)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        st0_d     = st0_q;
        reg_idx_d = reg_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (qd) begin
                    state_d = ST_RUN;
                    mode_d  = sw;
                    if (sw != mode_q) begin
                        st0_d     = 1'b0;
                        reg_idx_d = 2'd0;
                    end
                end
            end
            ST_RUN: begin
                if (mode_q == MODE_RUN && st0_q && beat[1] && op == OP_STP) begin
                    state_d = ST_HALT;
                end else if (beat_last) begin
                    if (mode_q == MODE_RUN) begin
                        st0_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        // write-reg alternates st0 so register pairs repeat the set-up decode
                        if (mode_q == MODE_WREG) begin
                            st0_d     = !st0_q;
                            reg_idx_d = reg_idx_q + 2'd1;
                        end else begin
                            st0_d = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_RUN;
            st0_q     <= 1'b0;
            reg_idx_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            st0_q     <= st0_d;
            reg_idx_q <= reg_idx_d;
        end
    end

    always_comb begin
        ctl = '0;
        if (state_q == ST_RUN) begin
            case (mode_q)
                MODE_WREG: begin
                    ctl[CTL_SELCTL]   = 1'b1;
                    ctl[CTL_SBUS]     = 1'b1;
                    ctl[CTL_SEL +: 4] = {reg_idx_q, 2'b00};
                    ctl[CTL_DRW]      = beat[1];
                end
                MODE_RREG: begin
                    ctl[CTL_SELCTL]   = 1'b1;
                    ctl[CTL_SEL +: 4] = beat[1] ? 4'b1011 : 4'b0001;
                end
                MODE_WMEM: begin
                    ctl[CTL_SBUS]  = 1'b1;
                    ctl[CTL_LAR]   = !st0_q;
                    ctl[CTL_MEMW]  = st0_q;
                    ctl[CTL_ARINC] = st0_q;
                end
                MODE_RMEM: begin
                    ctl[CTL_SBUS]  = !st0_q;
                    ctl[CTL_LAR]   = !st0_q;
                    ctl[CTL_MBUS]  = st0_q;
                    ctl[CTL_ARINC] = st0_q;
                end
                MODE_RUN: begin
                    if (!st0_q) begin
                        ctl[CTL_LPC]  = 1'b1;
                        ctl[CTL_SBUS] = 1'b1;
                    end else if (beat[0]) begin
                        ctl[CTL_LIR]   = 1'b1;
                        ctl[CTL_PCINC] = 1'b1;
                    end else if (beat[1]) begin
                        case (op)
                            OP_ADD: begin
                                ctl[CTL_S +: 4] = 4'b1001;
                                ctl[CTL_CIN] = 1'b1; ctl[CTL_ABUS] = 1'b1; ctl[CTL_DRW] = 1'b1;
                                ctl[CTL_LDZ] = 1'b1; ctl[CTL_LDC]  = 1'b1;
                            end
                            OP_SUB: begin
                                ctl[CTL_S +: 4] = 4'b0110;
                                ctl[CTL_ABUS] = 1'b1; ctl[CTL_DRW] = 1'b1;
                                ctl[CTL_LDZ]  = 1'b1; ctl[CTL_LDC] = 1'b1;
                            end
                            OP_AND: begin
                                ctl[CTL_S +: 4] = 4'b1011; ctl[CTL_M] = 1'b1;
                                ctl[CTL_ABUS] = 1'b1; ctl[CTL_DRW] = 1'b1; ctl[CTL_LDZ] = 1'b1;
                            end
                            OP_INC: begin
                                ctl[CTL_S +: 4] = 4'b0000;
                                ctl[CTL_ABUS] = 1'b1; ctl[CTL_DRW] = 1'b1;
                                ctl[CTL_LDZ]  = 1'b1; ctl[CTL_LDC] = 1'b1;
                            end
                            OP_LD: begin
                                ctl[CTL_S +: 4] = 4'b1010; ctl[CTL_M] = 1'b1;
                                ctl[CTL_ABUS] = 1'b1; ctl[CTL_LAR] = 1'b1;
                            end
                            OP_ST: begin
                                ctl[CTL_S +: 4] = 4'b1111; ctl[CTL_M] = 1'b1;
                                ctl[CTL_ABUS] = 1'b1; ctl[CTL_LAR] = 1'b1;
                            end
                            OP_JC:  ctl[CTL_PCADD] = c;
                            OP_JZ:  ctl[CTL_PCADD] = z;
                            OP_JMP: begin
                                ctl[CTL_S +: 4] = 4'b1111; ctl[CTL_M] = 1'b1;
                                ctl[CTL_ABUS] = 1'b1; ctl[CTL_LPC] = 1'b1;
                            end
                            OP_XOR: begin
                                ctl[CTL_S +: 4] = 4'b0110; ctl[CTL_M] = 1'b1;
                                ctl[CTL_ABUS] = 1'b1; ctl[CTL_DRW] = 1'b1; ctl[CTL_LDZ] = 1'b1;
                            end
                            OP_DEC: begin
                                ctl[CTL_S +: 4] = 4'b1111;
                                ctl[CTL_ABUS] = 1'b1; ctl[CTL_DRW] = 1'b1;
                                ctl[CTL_LDZ]  = 1'b1; ctl[CTL_LDC] = 1'b1;
                            end
                            default: ;
                        endcase
                    end else if (beat[2]) begin
                        case (op)
                            OP_LD: begin
                                ctl[CTL_MBUS] = 1'b1;
                                ctl[CTL_DRW]  = 1'b1;
                            end
                            OP_ST: begin
                                ctl[CTL_S +: 4] = 4'b1010; ctl[CTL_M] = 1'b1;
                                ctl[CTL_ABUS] = 1'b1; ctl[CTL_MEMW] = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // stop and halted together reveal the FSM state: neither set means RUN
    assign stop   = (state_q == ST_IDLE);
    assign halted = (state_q == ST_HALT);
    assign st0    = st0_q;

endmodule
